// File: rtl/systolic_pe_cfg.sv
// Parametrised pipelined MAC cell for the systolic array.
// Supports output-stationary (accumulate + drain) and weight-stationary (psum flows down) dataflows.
module systolic_pe_cfg #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned SIGNED = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_valid_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_valid_in,
    input  logic              w_load,
    input  logic [ACC_W-1:0]  psum_in,
    input  logic              psum_valid_in,
    input  logic              acc_clear,
    input  logic              drain,
    output logic [DATA_W-1:0] a_out,
    output logic              a_valid_out,
    output logic [DATA_W-1:0] b_out,
    output logic              b_valid_out,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_valid_out,
    output logic              ovf
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] UMAX = '1;
    // Bits above the raw product; all-zero when ACC_W equals PROD_W.
    localparam logic [ACC_W-1:0] EXT_MASK = ~((ACC_W'(1) << PROD_W) - ACC_W'(1));

    typedef enum logic {W_EMPTY, W_READY} w_state_t;

    w_state_t          w_state;
    logic [DATA_W-1:0] w;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  p;
    logic              p_v;

    logic [DATA_W-1:0] b_op;
    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  prod_ext;
    logic              p_v_next;

    // Stage 1: operand select, full-width product, extension to accumulator width.
    always_comb begin
        b_op  = mode ? w : b_in;
        a_ext = PROD_W'(a_in);
        b_ext = PROD_W'(b_op);
        if (SIGNED != 0) begin
            a_ext = {{DATA_W{a_in[DATA_W-1]}}, a_in};
            b_ext = {{DATA_W{b_op[DATA_W-1]}}, b_op};
        end
        prod     = a_ext * b_ext;
        prod_ext = ACC_W'(prod);
        if ((SIGNED != 0) && prod[PROD_W-1]) begin
            prod_ext = prod_ext | EXT_MASK;
        end
        p_v_next = a_valid_in & (mode ? (w_state == W_READY) : b_valid_in);
    end

    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] p_eff;
    logic [ACC_W-1:0] raw;
    logic             carry;
    logic [ACC_W-1:0] sum;
    logic             sum_sat;

    // Stage 2: one saturating adder shared by the OS accumulator and the WS psum path.
    always_comb begin
        p_eff = p_v ? p : '0;
        if (mode) begin
            base = psum_valid_in ? psum_in : '0;
        end else begin
            base = acc;
        end
        {carry, raw} = {1'b0, base} + {1'b0, p_eff};
        sum     = raw;
        sum_sat = 1'b0;
        if (SIGNED != 0) begin
            if ((base[ACC_W-1] == p_eff[ACC_W-1]) && (raw[ACC_W-1] != base[ACC_W-1])) begin
                sum_sat = 1'b1;
                sum     = base[ACC_W-1] ? SMIN : SMAX;
            end
        end else if (carry) begin
            sum_sat = 1'b1;
            sum     = UMAX;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_out          <= '0;
            a_valid_out    <= 1'b0;
            b_out          <= '0;
            b_valid_out    <= 1'b0;
            psum_out       <= '0;
            psum_valid_out <= 1'b0;
            ovf            <= 1'b0;
            w_state        <= W_EMPTY;
            w              <= '0;
            acc            <= '0;
            p              <= '0;
            p_v            <= 1'b0;
        end else begin
            a_out       <= a_in;
            a_valid_out <= a_valid_in;
            b_out       <= b_in;
            b_valid_out <= b_valid_in;
            p           <= prod_ext;
            p_v         <= p_v_next;

            // Weight FSM: a reload in W_READY simply overwrites w.
            if (acc_clear) begin
                w_state <= W_EMPTY;
            end else if (mode && w_load && b_valid_in) begin
                w       <= b_in;
                w_state <= W_READY;
            end

            if (!mode) begin
                if (drain) begin
                    psum_out       <= sum;
                    psum_valid_out <= 1'b1;
                    acc            <= '0;
                end else begin
                    if (p_v) begin
                        acc <= sum;
                    end
                    psum_valid_out <= psum_valid_in;
                    if (psum_valid_in) begin
                        psum_out <= psum_in;
                    end
                end
                // Clear then add; a drained product was already consumed by the drain.
                if (acc_clear) begin
                    acc            <= drain ? '0 : p_eff;
                    psum_valid_out <= drain;
                end
            end else begin
                if (p_v) begin
                    psum_out <= sum;
                end
                psum_valid_out <= p_v & ~acc_clear;
                if (acc_clear) begin
                    acc <= '0;
                end
            end

            ovf <= acc_clear ? 1'b0 : (ovf | sum_sat);
        end
    end

endmodule

// File: tb/tb_systolic_pe_cfg.sv
// Bench for systolic_pe_cfg: integer-arithmetic reference model checked every cycle,
// plus directed literal expectations on the default, saturating and unsigned configurations.
module tb_systolic_pe_cfg;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 40;
    localparam longint SMAX = (longint'(1) <<< (AW - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (AW - 1));

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mode = 1'b0;
    logic [DW-1:0] a_in = '0;
    logic          a_valid_in = 1'b0;
    logic [DW-1:0] b_in = '0;
    logic          b_valid_in = 1'b0;
    logic          w_load = 1'b0;
    logic [AW-1:0] psum_in = '0;
    logic          psum_valid_in = 1'b0;
    logic          acc_clear = 1'b0;
    logic          drain = 1'b0;
    logic [DW-1:0] a_out;
    logic          a_valid_out;
    logic [DW-1:0] b_out;
    logic          b_valid_out;
    logic [AW-1:0] psum_out;
    logic          psum_valid_out;
    logic          ovf;

    // Shared stimulus for the two narrow instances (8-bit operands, 20-bit accumulator).
    logic [7:0]  s_a = '0;
    logic        s_av = 1'b0;
    logic [7:0]  s_b = '0;
    logic        s_bv = 1'b0;
    logic        s_drain = 1'b0;
    logic        s_clear = 1'b0;
    logic [7:0]  s_a_out, u_a_out, s_b_out, u_b_out;
    logic        s_av_out, u_av_out, s_bv_out, u_bv_out;
    logic [19:0] s_ps, u_ps;
    logic        s_pv, u_pv, s_ovf, u_ovf;

    systolic_pe_cfg #(.DATA_W(DW), .ACC_W(AW), .SIGNED(1)) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
        .w_load(w_load), .psum_in(psum_in), .psum_valid_in(psum_valid_in),
        .acc_clear(acc_clear), .drain(drain),
        .a_out(a_out), .a_valid_out(a_valid_out), .b_out(b_out), .b_valid_out(b_valid_out),
        .psum_out(psum_out), .psum_valid_out(psum_valid_out), .ovf(ovf)
    );

    systolic_pe_cfg #(.DATA_W(8), .ACC_W(20), .SIGNED(1)) dut_s (
        .clk(clk), .reset(reset), .mode(1'b0),
        .a_in(s_a), .a_valid_in(s_av), .b_in(s_b), .b_valid_in(s_bv),
        .w_load(1'b0), .psum_in(20'd0), .psum_valid_in(1'b0),
        .acc_clear(s_clear), .drain(s_drain),
        .a_out(s_a_out), .a_valid_out(s_av_out), .b_out(s_b_out), .b_valid_out(s_bv_out),
        .psum_out(s_ps), .psum_valid_out(s_pv), .ovf(s_ovf)
    );

    systolic_pe_cfg #(.DATA_W(8), .ACC_W(20), .SIGNED(0)) dut_u (
        .clk(clk), .reset(reset), .mode(1'b0),
        .a_in(s_a), .a_valid_in(s_av), .b_in(s_b), .b_valid_in(s_bv),
        .w_load(1'b0), .psum_in(20'd0), .psum_valid_in(1'b0),
        .acc_clear(s_clear), .drain(s_drain),
        .a_out(u_a_out), .a_valid_out(u_av_out), .b_out(u_b_out), .b_valid_out(u_bv_out),
        .psum_out(u_ps), .psum_valid_out(u_pv), .ovf(u_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    longint ps_log[$];

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_log(input string name, input int n, input longint e0 = 0,
                             input longint e1 = 0, input longint e2 = 0, input longint e3 = 0);
        longint e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        check({name, "_count"}, longint'(ps_log.size()), longint'(n));
        for (int i = 0; i < n && i < int'(ps_log.size()); i++) begin
            check(name, ps_log[i], e[i]);
        end
    endtask

    function automatic longint clamp(input longint v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    // Reference model state: expected outputs plus the cell's architectural contents.
    logic [DW-1:0] e_a, e_b;
    bit     e_av, e_bv, e_pv, e_ovf;
    longint e_ps;
    longint m_acc, m_p, m_w;
    bit     m_pv, m_wrdy;
    longint m_peff, m_np, m_v;
    bit     m_npv;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e_a = '0; e_av = 0; e_b = '0; e_bv = 0;
            e_ps = 0; e_pv = 0; e_ovf = 0;
            m_acc = 0; m_p = 0; m_pv = 0; m_w = 0; m_wrdy = 0;
        end else begin
            m_peff = m_pv ? m_p : 64'sd0;
            m_np   = longint'($signed(a_in)) * (mode ? m_w : longint'($signed(b_in)));
            m_npv  = a_valid_in && (mode ? m_wrdy : b_valid_in);
            if (!mode) begin
                if (drain) begin
                    m_v = m_acc + m_peff;
                    if (clamp(m_v) != m_v) e_ovf = 1;
                    e_ps = clamp(m_v); e_pv = 1; m_acc = 0;
                end else begin
                    if (m_pv) begin
                        m_v = m_acc + m_peff;
                        if (clamp(m_v) != m_v) e_ovf = 1;
                        m_acc = clamp(m_v);
                    end
                    e_pv = psum_valid_in;
                    if (psum_valid_in) e_ps = longint'($signed(psum_in));
                end
                if (acc_clear) begin
                    m_acc = drain ? 64'sd0 : m_peff;
                    e_pv  = drain;
                end
            end else begin
                m_v = (psum_valid_in ? longint'($signed(psum_in)) : 64'sd0) + m_peff;
                if (m_pv) begin
                    if (clamp(m_v) != m_v) e_ovf = 1;
                    e_ps = clamp(m_v);
                end
                e_pv = m_pv && !acc_clear;
                if (acc_clear) m_acc = 0;
            end
            if (acc_clear) begin
                e_ovf = 0; m_wrdy = 0;
            end else if (mode && w_load && b_valid_in) begin
                m_w = longint'($signed(b_in)); m_wrdy = 1;
            end
            m_p = m_np; m_pv = m_npv;
            e_a = a_in; e_av = a_valid_in; e_b = b_in; e_bv = b_valid_in;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("a_out", longint'(a_out), longint'(e_a));
        check("a_valid_out", longint'(a_valid_out), longint'(e_av));
        check("b_out", longint'(b_out), longint'(e_b));
        check("b_valid_out", longint'(b_valid_out), longint'(e_bv));
        check("psum_valid_out", longint'(psum_valid_out), longint'(e_pv));
        check("ovf", longint'(ovf), longint'(e_ovf));
        if (e_pv) check("psum_out", longint'($signed(psum_out)), e_ps);
        if (psum_valid_out) ps_log.push_back(longint'($signed(psum_out)));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid_in = 0; b_valid_in = 0; w_load = 0;
        psum_valid_in = 0; acc_clear = 0; drain = 0;
    endtask

    int os_a[3] = '{3, -5, 7};
    int os_b[3] = '{4, 6, -2};
    int ws_a[5] = '{1, 2, 3, 4, 0};
    int ws_ps[5] = '{0, 100, 200, 300, 400};

    initial begin
        repeat (2) cyc();
        check("rst_a_valid_out", longint'(a_valid_out), 0);
        check("rst_psum_out", longint'(psum_out), 0);
        check("rst_ovf", longint'(ovf), 0);
        reset = 0;

        // Mid-stream asynchronous reset with every stream active.
        for (int i = 0; i < 4; i++) begin
            a_in = 16'(i + 7); a_valid_in = 1; b_in = 16'(3); b_valid_in = 1;
            psum_in = 40'(i + 11); psum_valid_in = 1;
            cyc();
        end
        @(posedge clk);
        #3 reset = 1;
        #1;
        check("async_a_out", longint'(a_out), 0);
        check("async_a_valid_out", longint'(a_valid_out), 0);
        check("async_b_valid_out", longint'(b_valid_out), 0);
        check("async_psum_out", longint'(psum_out), 0);
        check("async_psum_valid_out", longint'(psum_valid_out), 0);
        idle();
        cyc();
        reset = 0;
        ps_log.delete();
        cyc(); cyc();
        check("post_rst_a_valid_idle", longint'(a_valid_out), 0);
        a_in = 16'h1234; a_valid_in = 1;
        cyc();
        check("post_rst_a_valid_lat1", longint'(a_valid_out), 1);
        check("post_rst_a_out", longint'(a_out), 16'h1234);
        idle();
        check_log("post_rst_silent", 0);
        drain = 1; cyc(); idle(); cyc(); cyc();
        check_log("post_rst_drain_zero", 1, 0);

        // Output-stationary accumulate then drain.
        ps_log.delete();
        for (int i = 0; i < 3; i++) begin
            a_in = 16'(os_a[i]); b_in = 16'(os_b[i]); a_valid_in = 1; b_valid_in = 1;
            cyc();
        end
        idle(); cyc();
        drain = 1; cyc(); idle(); cyc(); cyc();
        check_log("os_drain", 1, -32);
        drain = 1; cyc(); idle(); cyc(); cyc();
        check_log("os_drain_again", 2, -32, 0);

        // Drain while a product is still in flight.
        ps_log.delete();
        a_in = 16'd10; b_in = 16'd10; a_valid_in = 1; b_valid_in = 1; cyc();
        idle(); drain = 1; cyc();
        idle(); cyc();
        drain = 1; cyc(); idle(); cyc(); cyc();
        check_log("os_inflight", 2, 100, 0);

        // Drain shift chain forwarding.
        ps_log.delete();
        psum_in = 40'd777; psum_valid_in = 1; cyc(); idle(); cyc(); cyc();
        check_log("os_forward", 1, 777);

        // Weight-stationary: no weight loaded yields no output.
        mode = 1; acc_clear = 1; cyc(); idle();
        ps_log.delete();
        for (int i = 0; i < 3; i++) begin
            a_in = 16'd2; a_valid_in = 1; psum_in = 40'd50; psum_valid_in = 1; cyc();
        end
        idle(); cyc(); cyc();
        check_log("ws_no_weight", 0);

        // Load w = 5, stream a with psum one cycle later, reload w = -1 mid-stream.
        b_in = 16'd5; b_valid_in = 1; w_load = 1; cyc(); idle();
        ps_log.delete();
        for (int i = 0; i < 5; i++) begin
            idle();
            a_in = 16'(ws_a[i]); a_valid_in = (i < 4);
            psum_in = 40'(ws_ps[i]); psum_valid_in = (i > 0);
            if (i == 2) begin
                b_in = 16'hFFFF; b_valid_in = 1; w_load = 1;
            end
            cyc();
        end
        idle(); cyc(); cyc();
        check_log("ws_flow", 4, 105, 210, 315, 396);

        mode = 0; acc_clear = 1; cyc(); idle(); cyc();

        // Narrow instances: 32 products of (-128)*(-128) saturate the signed 20-bit accumulator.
        s_a = 8'h80; s_b = 8'h80; s_av = 1; s_bv = 1;
        repeat (31) cyc();
        s_av = 0; s_bv = 0; cyc(); cyc();
        check("sat_ovf_before_32nd", longint'(s_ovf), 0);
        s_av = 1; s_bv = 1; cyc();
        s_av = 0; s_bv = 0; cyc(); cyc();
        check("sat_ovf_after_32nd", longint'(s_ovf), 1);
        check("unsigned_no_ovf", longint'(u_ovf), 0);
        s_drain = 1; cyc(); s_drain = 0;
        @(negedge clk);
        check("sat_drain_valid", longint'(s_pv), 1);
        check("sat_drain_value", longint'(s_ps), 524287);
        check("unsigned_large_value", longint'(u_ps), 524288);
        s_clear = 1; cyc(); s_clear = 0;
        @(negedge clk);
        check("sat_clear_ovf", longint'(s_ovf), 0);
        s_drain = 1; cyc(); s_drain = 0;
        @(negedge clk);
        check("sat_clear_acc", longint'(s_ps), 0);
        check("sat_clear_valid", longint'(s_pv), 1);

        // 0xFF * 0xFF: 65025 unsigned, (-1)*(-1) = 1 signed.
        s_a = 8'hFF; s_b = 8'hFF; s_av = 1; s_bv = 1; cyc();
        s_av = 0; s_bv = 0; cyc();
        s_drain = 1; cyc(); s_drain = 0;
        @(negedge clk);
        check("unsigned_drain", longint'(u_ps), 65025);
        check("signed_ff_drain", longint'(s_ps), 1);

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_pe_cfg.md
# systolic_pe_cfg

Parametrised, pipelined multiply-accumulate cell for the systolic array, the next generation of the fixed 16-bit PE. It adds configurable operand and accumulator width, signed or unsigned arithmetic, valid qualifiers on every stream, and two dataflow modes. In output-stationary (OS) mode the sum accumulates locally and is drained on demand. In weight-stationary (WS) mode a preloaded weight multiplies streaming activations and partial sums flow downward. Cells tile in a grid: a flows right, b flows down, psum flows down.

## Interface
- DATA_W, 16, operand width of a and b.
- ACC_W, 40, accumulator / psum width; must be ≥ 2*DATA_W.
- SIGNED, 1, 1 = two's-complement operands and accumulator; 0 = unsigned.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clock clk.
- mode  in  1  0 = OS, 1 = WS. Quasi-static: change only with acc_clear asserted in the same cycle.
- a_in / a_valid_in  in  DATA_W / 1  activation from left neighbour.
- b_in / b_valid_in  in  DATA_W / 1  operand from top neighbour; carries the weight during WS load.
- w_load  in  1  WS only: with b_valid_in, latch b_in as the weight.
- psum_in / psum_valid_in  in  ACC_W / 1  partial sum from top neighbour.
- acc_clear  in  1  synchronous clear of accumulator, weight-valid flag and ovf.
- drain  in  1  OS only: emit the accumulator on psum_out.
- a_out / a_valid_out  out  DATA_W / 1  registered copy of a_in / a_valid_in.
- b_out / b_valid_out  out  DATA_W / 1  registered copy of b_in / b_valid_in, including during w_load.
- psum_out / psum_valid_out  out  ACC_W / 1  partial sum to bottom neighbour.
- ovf  out  1  sticky saturation flag.

## Operation
- **Stage 1 (product register)**
  - OS: p <= a_in*b_in; p_v <= a_valid_in & b_valid_in.
  - WS: p <= a_in*w; p_v <= a_valid_in & w_vld.
  - Product is full 2*DATA_W, sign- or zero-extended to ACC_W per SIGNED.
- **Weight FSM (WS only)**
  - Two states: W_EMPTY and W_READY.
  - W_EMPTY → W_READY on w_load & b_valid_in; w <= b_in.
  - Reloading in W_READY overwrites w. The new w applies to stage-1 products from the next cycle onward.
  - acc_clear or reset → W_EMPTY.
  - In W_EMPTY, p_v = 0: no products are issued.
- **OS stage 2**
  - If p_v, acc <= sat(acc + p).
  - drain: psum_out <= sat(acc + (p_v ? p : 0)); psum_valid_out <= 1; acc <= 0. The in-flight product is included, not lost.
  - Otherwise, if psum_valid_in, forward psum_in → psum_out with psum_valid_out = 1. This is the drain shift chain.
  - drain and psum_valid_in in the same cycle: drain wins and psum_in is dropped. This is a protocol error for the controller to avoid.
- **WS stage 2**
  - psum_out <= sat(psum_in + p), with psum_valid_out <= p_v.
  - psum_in is taken as 0 when psum_valid_in = 0. Top-row cells tie it low.
  - drain is ignored.
- **Saturation**
  - SIGNED = 1: clamp to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - SIGNED = 0: clamp to 2^ACC_W−1.
  - Any clamp sets ovf. ovf stays set until acc_clear or reset.
- **acc_clear**
  - acc <= 0 and ovf <= 0.
  - A p_v product in the same cycle is then loaded: acc <= p. Clear happens first, then add.
  - a/b forwarding is unaffected.
  - psum_valid_out <= 0 in that cycle unless drain is also asserted. In that case the drain value is emitted, then clear takes effect.

## Timing
- Reset (async assert, sync release): every output, acc, w, p and p_v are 0; weight FSM in W_EMPTY.
- a_out, b_out and their valids: latency 1.
- OS: a/b to acc updated at latency 2. drain to psum_out valid at latency 1.
- WS: psum_out(t+2) = psum_in(t+1) + a(t)*w. psum_in must be presented one cycle after the paired a_in, and psum_out of the upper cell meets that alignment automatically.
- Fully pipelined: one MAC per cycle with no bubbles. No back-pressure exists; valids are qualifiers only.
- Mid-operation reset: in-flight product and valid are discarded; nothing is emitted after release until new valid input arrives.

## Test plan
- **Reset:** drive nonzero inputs, assert reset mid-stream → all outputs 0 the same cycle; after release, first a_valid_out follows one cycle after the first a_valid_in.
- **OS accumulate/drain:** DATA_W=16, SIGNED=1; pairs (3,4), (−5,6), (7,−2), then drain on the cycle after the last p_v → psum_out = −32 valid exactly once; subsequent drain → 0.
- **OS drain with in-flight product:** (10,10) then drain in the cycle p_v is high → psum_out = 100; acc = 0 afterwards.
- **WS flow:** w_load with b_in = 5; stream a = 1, 2, 3 with psum_in = 100, 200, 300 aligned one cycle later → psum_out = 105, 210, 315 at t+2; reload w = −1 mid-stream → following outputs use −1. With no weight loaded → psum_valid_out stays 0.
- **Saturation:** DATA_W=8, ACC_W=20, SIGNED=1; 32 products of (−128)*(−128) = 16384 → acc clamps at 524287 on the 32nd and ovf = 1; acc_clear → ovf = 0, acc = 0.
- **Unsigned:** SIGNED=0, DATA_W=8: 255*255 = 65025; drain → psum_out = 65025 with no sign extension.
